// File: rtl/sam_pkg.sv
// Shared opcode and FSM state definitions for the SAM accumulator core.
package sam_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_BRN   = 3'b110;
    localparam logic [2:0] OP_BRZ   = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPER,
        S_EXEC,
        S_ERR
    } state_t;

endpackage

// File: rtl/sam_alu.sv
// Combinational accumulator ALU: produces the next AC value and its N/Z flags.
module sam_alu
    import sam_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z
);

    always_comb begin
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            default: result = b;
        endcase
    end

    assign n = result[WIDTH-1];
    assign z = (result == '0);

endmodule

// File: rtl/sam_core_param.sv
// SAM accumulator CPU with a hardwired FSM and REQUEST/RW/WAIT memory handshake.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_FETCH  | read instruction at PC into IR, advance PC
//   S_DECODE | resolve JMP/BRN/BRZ (retire) or move on to the operand access
//   S_OPER   | STORE writes AC (retire); other ops read operand into MBR
//   S_EXEC   | ALU result into AC, update flags, retire
//   S_ERR    | wait timeout; bus_err high, core frozen until reset
module sam_core_param
    import sam_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PC_STEP  = 2,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_req,
    output logic             mem_rw,
    input  logic             mem_wait,
    output logic [WIDTH-1:0] ac_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             retire,
    output logic             bus_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, mbr_q, mbr_d, ac_q, ac_d;
    logic             flag_n_q, flag_n_d, flag_z_q, flag_z_d;
    logic             req_q, req_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [2:0]       op;
    logic [WIDTH-1:0] operand, alu_res;
    logic             alu_n, alu_z, done, stall;

    assign op      = ir_q[WIDTH-1 -: 3];
    assign operand = {3'b000, ir_q[WIDTH-4:0]};
    assign done    = req_q & ~mem_wait;
    assign stall   = req_q & mem_wait;

    sam_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op),
        .a      (ac_q),
        .b      (mbr_q),
        .result (alu_res),
        .n      (alu_n),
        .z      (alu_z)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= WIDTH'(RESET_PC);
            ir_q     <= '0;
            mbr_q    <= '0;
            ac_q     <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b1;
            req_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mbr_q    <= mbr_d;
            ac_q     <= ac_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mbr_d    = mbr_q;
        ac_d     = ac_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        cnt_d    = '0;
        retire   = 1'b0;
        mem_addr = pc_q;
        mem_rw   = 1'b1;

        case (state_q)
            S_FETCH: begin
                if (done) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + WIDTH'(PC_STEP);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_JMP: begin
                        pc_d    = operand;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_BRN: begin
                        if (flag_n_q) pc_d = operand;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_BRZ: begin
                        if (flag_z_q) pc_d = operand;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_OPER;
                endcase
            end
            S_OPER: begin
                mem_addr = operand;
                mem_rw   = (op != OP_STORE);
                if (done) begin
                    if (op == OP_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mbr_d   = mem_rdata;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                ac_d     = alu_res;
                flag_n_d = alu_n;
                flag_z_d = alu_z;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_ERR;
        endcase

        // Counter only runs while an access is stalled; any other cycle clears it.
        if (stall) begin
            if (TIMEOUT > 0 && cnt_q == TO_LAST) state_d = S_ERR;
            else cnt_d = cnt_q + 1'b1;
        end

        req_d = (state_d == S_FETCH) || (state_d == S_OPER);
    end

    assign mem_req   = req_q;
    assign mem_wdata = ac_q;
    assign ac_out    = ac_q;
    assign pc_out    = pc_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;
    assign bus_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_sam_core_param.sv
// Bench for sam_core_param: directed scenarios plus random programs against an ISA-level model.
module tb_sam_core_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] mem_addr, mem_wdata, mem_rdata, ac_out, pc_out;
    logic        mem_req, mem_rw, mem_wait, flag_n, flag_z, retire, bus_err;
    logic [7:0]  m8_addr, m8_wdata, m8_rdata, ac8, pc8;
    logic        m8_req, m8_rw, m8_wait, fn8, fz8, ret8, berr8;

    logic [15:0] mem  [0:255];
    logic [15:0] img  [0:255];
    logic [7:0]  mem8 [0:255];
    logic [7:0]  img8 [0:255];
    logic [15:0] mmem [0:255];
    logic [15:0] mpc, mac;

    logic        load = 1'b0, stuck = 1'b0, hold_wr = 1'b0;
    int unsigned wait_init = 0, wait_max = 0, wait_left;
    int          errors = 0, checks = 0;

    sam_core_param #(.WIDTH(16), .PC_STEP(2), .RESET_PC(0), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_wait(mem_wait),
        .ac_out(ac_out), .pc_out(pc_out), .flag_n(flag_n), .flag_z(flag_z),
        .retire(retire), .bus_err(bus_err)
    );

    sam_core_param #(.WIDTH(8), .PC_STEP(1), .RESET_PC(255), .TIMEOUT(64)) dut8 (
        .clk(clk), .reset(reset),
        .mem_addr(m8_addr), .mem_wdata(m8_wdata), .mem_rdata(m8_rdata),
        .mem_req(m8_req), .mem_rw(m8_rw), .mem_wait(m8_wait),
        .ac_out(ac8), .pc_out(pc8), .flag_n(fn8), .flag_z(fz8),
        .retire(ret8), .bus_err(berr8)
    );

    // Memory models: combinational read, write at the completing edge.
    assign mem_rdata = mem[mem_addr[7:0]];
    assign mem_wait  = stuck | (mem_req & (wait_left != 0)) | (mem_req & ~mem_rw & hold_wr);
    assign m8_rdata  = mem8[m8_addr];
    assign m8_wait   = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (mem_req && !mem_wait && !mem_rw) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        if (reset) wait_left <= wait_init;
        else if (mem_req && !mem_wait) wait_left <= $urandom_range(wait_max);
        else if (mem_req && wait_left != 0) wait_left <= wait_left - 1;
    end

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem8[i] <= img8[i];
        end else if (m8_req && !m8_wait && !m8_rw) begin
            mem8[m8_addr] <= m8_wdata;
        end
    end

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [12:0] a);
        return {op, a};
    endfunction

    function automatic logic [7:0] ins8(input logic [2:0] op, input logic [4:0] a);
        return {op, a};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img;
        for (int i = 0; i < 256; i++) begin
            img[i]  = '0;
            img8[i] = '0;
        end
    endtask

    task automatic start;
        reset = 1'b1;
        load  = 1'b1;
        tick;
        load  = 1'b0;
        tick;
        reset = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_req: mem_req=%b, required 1 within 20 cycles", mem_req);
        end
    endtask

    // Returns just after the edge that commits the next retiring instruction.
    task automatic wait_retire(input bit sel);
        for (int i = 0; i < 40; i++) begin
            if (sel ? ret8 : retire) begin
                tick;
                return;
            end
            tick;
        end
        checks++; errors++;
        $display("FAIL wait_retire(%0d): no retire within 40 cycles, required one", sel);
    endtask

    // ISA-level reference: executes one instruction on mpc/mac/mmem.
    task automatic model_step;
        logic [15:0] w, a;
        logic [2:0]  op;
        w   = mmem[mpc[7:0]];
        mpc = mpc + 16'd2;
        op  = w[15:13];
        a   = {3'b000, w[12:0]};
        case (op)
            3'd0: mac = mmem[a[7:0]];
            3'd1: mmem[a[7:0]] = mac;
            3'd2: mac = mac + mmem[a[7:0]];
            3'd3: mac = mac - mmem[a[7:0]];
            3'd4: mac = mac & mmem[a[7:0]];
            3'd5: mpc = a;
            3'd6: if ($signed(mac) < 0) mpc = a;
            default: if (mac == 16'd0) mpc = a;
        endcase
    endtask

    task automatic test_reset;
        clear_img;
        reset = 1'b1;
        tick;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
        checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL reset mem_rw: got %b want 1", mem_rw); end
        checks++; if (pc_out !== 16'h0) begin errors++; $display("FAIL reset pc: got %h want 0000", pc_out); end
        checks++; if (ac_out !== 16'h0) begin errors++; $display("FAIL reset ac: got %h want 0000", ac_out); end
        checks++; if ({flag_n, flag_z} !== 2'b01) begin errors++; $display("FAIL reset flags n,z: got %b want 01", {flag_n, flag_z}); end
        checks++; if ({retire, bus_err} !== 2'b00) begin errors++; $display("FAIL reset retire,bus_err: got %b want 00", {retire, bus_err}); end
        checks++; if (pc8 !== 8'hFF) begin errors++; $display("FAIL reset pc8: got %h want ff", pc8); end
    endtask

    task automatic test_basic;
        bit ok;
        int n_ret, last;
        clear_img;
        img[0]    = ins(3'd0, 13'h10); img[16'h10] = 16'd5;
        img[2]    = ins(3'd2, 13'h11); img[16'h11] = 16'd7;
        img[4]    = ins(3'd1, 13'h12);
        img[6]    = ins(3'd5, 13'h06);
        start;
        wait_req(ok);
        n_ret = 0; last = 0;
        for (int c = 1; c <= 11; c++) begin
            if (retire) begin
                n_ret++;
                last = c;
            end
            tick;
        end
        checks++; if (n_ret != 3) begin errors++; $display("FAIL basic retire count: got %0d want 3", n_ret); end
        checks++; if (last != 11) begin errors++; $display("FAIL basic third retire cycle: got %0d want 11", last); end
        checks++; if (mem[8'h12] !== 16'd12) begin errors++; $display("FAIL basic mem[12]: got %h want 000c", mem[8'h12]); end
        checks++; if (ac_out !== 16'd12) begin errors++; $display("FAIL basic ac: got %h want 000c", ac_out); end
        checks++; if ({flag_n, flag_z} !== 2'b00) begin errors++; $display("FAIL basic flags n,z: got %b want 00", {flag_n, flag_z}); end
    endtask

    task automatic test_sub_branch;
        int cyc;
        clear_img;
        img[0] = ins(3'd0, 13'h10); img[16'h10] = 16'd3;
        img[2] = ins(3'd3, 13'h11); img[16'h11] = 16'd5;
        img[4] = ins(3'd7, 13'h30);
        img[6] = ins(3'd6, 13'h20);
        img[16'h20] = ins(3'd5, 13'h20);
        img[16'h30] = ins(3'd5, 13'h30);
        start;
        wait_retire(1'b0);
        wait_retire(1'b0);
        checks++; if (ac_out !== 16'hFFFE) begin errors++; $display("FAIL sub ac: got %h want fffe", ac_out); end
        checks++; if ({flag_n, flag_z} !== 2'b10) begin errors++; $display("FAIL sub flags n,z: got %b want 10", {flag_n, flag_z}); end
        wait_retire(1'b0);
        checks++; if (pc_out !== 16'h0006) begin errors++; $display("FAIL brz not-taken pc: got %h want 0006", pc_out); end
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            cyc++;
            if (retire) break;
            tick;
        end
        checks++; if (cyc != 2) begin errors++; $display("FAIL brn latency: got %0d want 2", cyc); end
        tick;
        checks++; if (pc_out !== 16'h0020) begin errors++; $display("FAIL brn taken pc: got %h want 0020", pc_out); end
    endtask

    task automatic test_wait_fetch;
        bit ok, stable;
        int ret_cyc;
        clear_img;
        img[0] = ins(3'd0, 13'h10); img[16'h10] = 16'h1234;
        img[2] = ins(3'd5, 13'h02);
        wait_init = 3; wait_max = 0;
        start;
        wait_req(ok);
        stable = 1'b1; ret_cyc = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4 && (mem_addr !== 16'h0 || mem_rw !== 1'b1 || mem_req !== 1'b1)) stable = 1'b0;
            if (retire && ret_cyc == 0) ret_cyc = c;
            tick;
        end
        wait_init = 0;
        checks++; if (!stable) begin errors++; $display("FAIL wait addr/rw hold: got unstable want addr=0000 rw=1 for 4 cycles"); end
        checks++; if (ret_cyc != 7) begin errors++; $display("FAIL wait load latency: got %0d want 7", ret_cyc); end
        checks++; if (ac_out !== 16'h1234) begin errors++; $display("FAIL wait ac: got %h want 1234", ac_out); end
    endtask

    task automatic test_timeout;
        bit ok;
        int n;
        clear_img;
        img[0] = ins(3'd0, 13'h10);
        stuck = 1'b1;
        start;
        wait_req(ok);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_err) break;
            n++;
            tick;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL timeout wait cycles: got %0d want 4", n); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL timeout mem_req: got %b want 0", mem_req); end
        stuck = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        checks++; if (pc_out !== 16'h0) begin errors++; $display("FAIL timeout pc frozen: got %h want 0000", pc_out); end
        checks++; if ({bus_err, mem_req} !== 2'b10) begin errors++; $display("FAIL timeout sticky bus_err,req: got %b want 10", {bus_err, mem_req}); end
        reset = 1'b1;
        tick;
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL timeout reset clears bus_err: got %b want 0", bus_err); end
    endtask

    task automatic test_reset_mid_store;
        bit seen;
        clear_img;
        img[0] = ins(3'd0, 13'h10); img[16'h10] = 16'h1234;
        img[2] = ins(3'd1, 13'h12); img[16'h12] = 16'hAAAA;
        img[4] = ins(3'd5, 13'h04);
        hold_wr = 1'b1;
        start;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req && !mem_rw) begin
                seen = 1'b1;
                break;
            end
            tick;
        end
        checks++; if (!seen) begin errors++; $display("FAIL midstore write request: got none want one within 20 cycles"); end
        tick;
        reset = 1'b1;
        tick;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midstore mem_req: got %b want 0", mem_req); end
        checks++; if (pc_out !== 16'h0 || ac_out !== 16'h0) begin errors++; $display("FAIL midstore pc,ac: got %h,%h want 0000,0000", pc_out, ac_out); end
        hold_wr = 1'b0;
        tick;
        tick;
        checks++; if (mem[8'h12] !== 16'hAAAA) begin errors++; $display("FAIL midstore mem[12]: got %h want aaaa", mem[8'h12]); end
    endtask

    task automatic test_wrap8;
        clear_img;
        img8[8'hFF] = ins8(3'd0, 5'h10); img8[8'h10] = 8'hF0;
        img8[8'h00] = ins8(3'd2, 5'h11); img8[8'h11] = 8'h20;
        img8[8'h01] = ins8(3'd5, 5'h01);
        img[0]      = ins(3'd5, 13'h00);
        start;
        wait_retire(1'b1);
        checks++; if (pc8 !== 8'h00) begin errors++; $display("FAIL wrap8 pc: got %h want 00", pc8); end
        checks++; if (ac8 !== 8'hF0 || fn8 !== 1'b1) begin errors++; $display("FAIL wrap8 load ac,n: got %h,%b want f0,1", ac8, fn8); end
        wait_retire(1'b1);
        checks++; if (ac8 !== 8'h10) begin errors++; $display("FAIL wrap8 add ac: got %h want 10", ac8); end
        checks++; if ({fn8, fz8, berr8} !== 3'b000) begin errors++; $display("FAIL wrap8 n,z,bus_err: got %b want 000", {fn8, fz8, berr8}); end
        checks++; if (pc8 !== 8'h01) begin errors++; $display("FAIL wrap8 pc after add: got %h want 01", pc8); end
    endtask

    task automatic test_random;
        int retired;
        logic [2:0] op;
        clear_img;
        for (int i = 0; i < 31; i++) begin
            op = 3'($urandom_range(7));
            if (op >= 3'd5) img[2*i] = ins(op, 13'(2 * $urandom_range(31)));
            else            img[2*i] = ins(op, 13'(16'h80 + $urandom_range(15)));
        end
        img[16'h3E] = ins(3'd5, 13'h0);
        for (int i = 16'h80; i < 16'h90; i++) img[i] = 16'($urandom);
        for (int i = 0; i < 256; i++) mmem[i] = img[i];
        mpc = 16'h0; mac = 16'h0;
        wait_max  = 2;
        wait_init = $urandom_range(2);
        start;
        retired = 0;
        for (int cyc = 0; cyc < 3000 && retired < 150; cyc++) begin
            if (retire) begin
                tick;
                model_step;
                retired++;
                checks++; if (pc_out !== mpc) begin errors++; $display("FAIL random pc #%0d: got %h want %h", retired, pc_out, mpc); end
                checks++; if (ac_out !== mac) begin errors++; $display("FAIL random ac #%0d: got %h want %h", retired, ac_out, mac); end
                checks++; if ({flag_n, flag_z} !== {mac[15], mac == 16'h0}) begin
                    errors++; $display("FAIL random flags #%0d: got %b want %b", retired, {flag_n, flag_z}, {mac[15], mac == 16'h0});
                end
            end else begin
                tick;
            end
        end
        checks++; if (retired < 150) begin errors++; $display("FAIL random progress: got %0d retires want 150", retired); end
        for (int i = 16'h80; i < 16'h90; i++) begin
            checks++; if (mem[i] !== mmem[i]) begin errors++; $display("FAIL random mem[%h]: got %h want %h", i, mem[i], mmem[i]); end
        end
        wait_max = 0; wait_init = 0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_sub_branch;
        test_wait_fetch;
        test_timeout;
        test_reset_mid_store;
        test_wrap8;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
